sh7604_bus_arb: RTL and testbench
=================================

# sh7604_bus_arb

Arbitrates ownership of the SH7604 external bus between three masters: the internal master path, the BSC refresh engine and an external master. The internal path is CPU/DMAC traffic after the DMAC mux. The external master uses the BRLS/BGR handshake. The block sits between the DMAC DBUS output and the BSC. It stalls internal traffic while the bus is owned elsewhere, respects the DMAC bus lock, and inserts programmable turnaround cycles around external ownership.

## Interface
- TURN_CYC, 1, bus turnaround length in CE_R ticks on each side of external ownership; legal range 0–3.
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- CE_R  in  1  rising-phase clock enable; all state changes occur only on CLK edges with CE_R=1.
- CE_F  in  1  falling-phase clock enable; unused by the FSM and reserved for BSC alignment.
- INT_REQ  in  1  internal bus request (DMAC DBUS_REQ).
- INT_LOCK  in  1  internal lock (DMAC DBUS_LOCK); the bus must not change owner while it is high.
- BSC_BUSY  in  1  a BSC transfer is in progress (DBUS_WAIT).
- INT_GNT  out  1  internal master owns the bus.
- INT_HOLD  out  1  stall to the internal master; combinational, INT_REQ & ~INT_GNT.
- REF_REQ  in  1  refresh request, level, held until served.
- REF_DONE  in  1  one-cycle pulse when the refresh cycle completes.
- REF_GNT  out  1  refresh may start.
- BRLS_N  in  1  external bus request, active-low, asynchronous.
- BGR_N  out  1  bus grant to the external master, active-low.
- BUS_HIZ  out  1  tri-state the address, data and strobe pins.
- OWNER  out  2  current owner: 00 none, 01 internal, 10 refresh, 11 external.

## Operation
- BRLS_N passes through a 2-flop synchroniser clocked on every CLK, not gated by CE_R, giving BRLS_S. All decisions use BRLS_S.
- States: IDLE, INT, REF, TOUT (turn-out), EXT, TIN (turn-in). TURN_CNT is 2 bits. INT_FIRST is a 1-bit fairness flag.
- IDLE priority:
  - REF_REQ → REF.
  - Otherwise, if INT_FIRST=1 and INT_REQ → INT.
  - Otherwise, ext pending (BRLS_S=0) → TOUT, or straight to EXT when TURN_CYC=0.
  - Otherwise INT_REQ → INT.
- INT: INT_GNT=1, and INT_FIRST clears on entry.
  - Leave to IDLE only at a transfer boundary: BSC_BUSY=0 & INT_LOCK=0 & (INT_REQ=0 | REF_REQ | BRLS_S=0).
  - The lock overrides all other requesters indefinitely.
- REF: REF_GNT=1; REF_DONE → IDLE.
- TOUT: BUS_HIZ=1 and BGR_N=1. TURN_CNT counts up from 0, and the state moves to EXT when TURN_CNT==TURN_CYC-1.
  - If BRLS_S rises during TOUT → IDLE with no grant; BUS_HIZ drops on the same edge.
- EXT: BGR_N=0 and BUS_HIZ=1.
  - The external master cannot be preempted; REF_REQ and INT_REQ wait.
  - BRLS_S=1 → TIN, or → IDLE when TURN_CYC=0. INT_FIRST is set on exit.
- TIN: BGR_N=1 and BUS_HIZ=1 for TURN_CYC ticks, then → IDLE.
- Only one of INT_GNT, REF_GNT or BGR_N asserted is ever active; an assertion check covers this.

## Timing
- Reset values: state IDLE, OWNER=00, INT_GNT=0, REF_GNT=0, BGR_N=1, BUS_HIZ=0, INT_FIRST=0, TURN_CNT=0, synchroniser flops=1.
- Reset is asynchronous. Asserting RST_N mid-EXT returns BGR_N to 1 and BUS_HIZ to 0 immediately, with no CE_R dependence.
- All outputs except INT_HOLD are registered and update on CE_R edges.
- Latencies:
  - IDLE + INT_REQ → INT_GNT after 1 CE_R tick.
  - REF_REQ → REF_GNT after 1 tick.
  - BRLS_N fall → BGR_N low after 2 CLK of synchronisation plus 1 + TURN_CYC CE_R ticks.
- Simultaneous events:
  - REF_REQ and BRLS_S=0 at an INT boundary: refresh is served first, then external.
  - INT_REQ and BRLS_S=0 in IDLE: external wins unless INT_FIRST=1.
- REF_DONE outside REF is ignored.
- BRLS_S toggling in EXT is resampled every tick; a high sample releases the bus.

## Test plan
- Reset, then INT_REQ=1 with CE_R every cycle → INT_GNT=1 and OWNER=01 one tick later; INT_HOLD=0.
- In INT with INT_LOCK=1 and BRLS_N=0 for 50 ticks → BGR_N stays 1. Drop the lock with BSC_BUSY=0 → IDLE, then TOUT (1 tick, BUS_HIZ=1), then BGR_N=0 on the tick after.
- TURN_CYC=3: BRLS_N low → BUS_HIZ=1 for 3 ticks before BGR_N=0. Release → BGR_N=1 and BUS_HIZ=1 for 3 ticks, then IDLE. With INT_REQ pending, INT_GNT=1 next even though BRLS_N is low again (INT_FIRST).
- In INT, raise REF_REQ and BRLS_N=0 in the same tick at a boundary → REF_GNT=1. REF_DONE → IDLE, then TOUT, then EXT.
- BRLS_N pulses low then high during TOUT (TURN_CYC=2) → no BGR_N assertion and return to IDLE.
- Assert RST_N=0 asynchronously while BGR_N=0 → BGR_N=1, BUS_HIZ=0 and OWNER=00 without a clock edge.

Source files
------------

// File: rtl/sh7604_bus_arb.sv
// SH7604 external bus arbiter: internal master path, BSC refresh engine and an
// external BRLS/BGR master, with programmable turnaround around external ownership.
module sh7604_bus_arb #(
    parameter int unsigned TURN_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE_R,
    input  logic       CE_F,
    input  logic       INT_REQ,
    input  logic       INT_LOCK,
    input  logic       BSC_BUSY,
    output logic       INT_GNT,
    output logic       INT_HOLD,
    input  logic       REF_REQ,
    input  logic       REF_DONE,
    output logic       REF_GNT,
    input  logic       BRLS_N,
    output logic       BGR_N,
    output logic       BUS_HIZ,
    output logic [1:0] OWNER
);

    typedef enum logic [2:0] {
        S_IDLE, S_INT, S_REF, S_TOUT, S_EXT, S_TIN
    } state_e;

    localparam logic       TURN_ZERO = (TURN_CYC == 0);
    localparam logic [1:0] TURN_LAST = (TURN_CYC == 0) ? 2'd0 : 2'(TURN_CYC - 1);

    state_e     state, state_n;
    logic [1:0] turn_cnt, turn_cnt_n;
    logic       int_first, int_first_n;
    logic       brls_q1, brls_s;
    logic [1:0] owner_n;
    logic       unused_ce_f;

    assign unused_ce_f = CE_F;

    // BRLS_N is asynchronous to us; synchronise on every clock regardless of CE_R.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            brls_q1 <= 1'b1;
            brls_s  <= 1'b1;
        end else begin
            brls_q1 <= BRLS_N;
            brls_s  <= brls_q1;
        end
    end

    always_comb begin
        state_n     = state;
        turn_cnt_n  = turn_cnt;
        int_first_n = int_first;
        case (state)
            S_IDLE: begin
                if (REF_REQ)
                    state_n = S_REF;
                else if (int_first && INT_REQ)
                    state_n = S_INT;
                else if (!brls_s) begin
                    state_n    = TURN_ZERO ? S_EXT : S_TOUT;
                    turn_cnt_n = 2'd0;
                end else if (INT_REQ)
                    state_n = S_INT;
            end
            S_INT: begin
                // Only release at a transfer boundary; the lock pins ownership.
                if (!BSC_BUSY && !INT_LOCK && (!INT_REQ || REF_REQ || !brls_s))
                    state_n = S_IDLE;
            end
            S_REF: begin
                if (REF_DONE)
                    state_n = S_IDLE;
            end
            S_TOUT: begin
                if (brls_s)
                    state_n = S_IDLE;
                else if (turn_cnt == TURN_LAST)
                    state_n = S_EXT;
                else
                    turn_cnt_n = turn_cnt + 2'd1;
            end
            S_EXT: begin
                if (brls_s) begin
                    int_first_n = 1'b1;
                    state_n     = TURN_ZERO ? S_IDLE : S_TIN;
                    turn_cnt_n  = 2'd0;
                end
            end
            S_TIN: begin
                if (turn_cnt == TURN_LAST)
                    state_n = S_IDLE;
                else
                    turn_cnt_n = turn_cnt + 2'd1;
            end
            default: state_n = S_IDLE;
        endcase
        if (state_n == S_INT && state != S_INT)
            int_first_n = 1'b0;
    end

    always_comb begin
        owner_n = 2'b00;
        case (state_n)
            S_INT:   owner_n = 2'b01;
            S_REF:   owner_n = 2'b10;
            S_EXT:   owner_n = 2'b11;
            default: owner_n = 2'b00;
        endcase
    end

    // Outputs are registered from the next state so they change with the state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            turn_cnt  <= 2'd0;
            int_first <= 1'b0;
            INT_GNT   <= 1'b0;
            REF_GNT   <= 1'b0;
            BGR_N     <= 1'b1;
            BUS_HIZ   <= 1'b0;
            OWNER     <= 2'b00;
        end else if (CE_R) begin
            state     <= state_n;
            turn_cnt  <= turn_cnt_n;
            int_first <= int_first_n;
            INT_GNT   <= (state_n == S_INT);
            REF_GNT   <= (state_n == S_REF);
            BGR_N     <= (state_n != S_EXT);
            BUS_HIZ   <= (state_n == S_TOUT) || (state_n == S_EXT) || (state_n == S_TIN);
            OWNER     <= owner_n;
        end
    end

    assign INT_HOLD = INT_REQ & ~INT_GNT;

    always_comb begin
        assert ($onehot0({INT_GNT, REF_GNT, ~BGR_N}));
    end

endmodule

// File: tb/tb_sh7604_bus_arb.sv
// Directed bench for sh7604_bus_arb: four instances (TURN_CYC 1,3,2,0) share
// stimulus; each phase checks one instance against a queued expected state.
module tb_sh7604_bus_arb;

    localparam int D1 = 0;  // TURN_CYC=1
    localparam int D3 = 1;  // TURN_CYC=3
    localparam int D2 = 2;  // TURN_CYC=2
    localparam int D0 = 3;  // TURN_CYC=0

    typedef enum int {B_IDLE, B_INT, B_REF, B_TOUT, B_EXT, B_TIN} bst_e;

    typedef struct {
        string      tag;
        int         d;
        logic [6:0] exp;
    } sb_t;

    logic CLK = 1'b0;
    logic RST_N, CE_R, CE_F, INT_REQ, INT_LOCK, BSC_BUSY, REF_REQ, REF_DONE, BRLS_N;
    logic       int_gnt  [4];
    logic       int_hold [4];
    logic       ref_gnt  [4];
    logic       bgr_n    [4];
    logic       bus_hiz  [4];
    logic [1:0] owner    [4];

    sb_t sb_q[$];
    int  vectors     = 0;
    int  miscompares = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned TC = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 0;
        sh7604_bus_arb #(.TURN_CYC(TC)) dut (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .CE_R     (CE_R),
            .CE_F     (CE_F),
            .INT_REQ  (INT_REQ),
            .INT_LOCK (INT_LOCK),
            .BSC_BUSY (BSC_BUSY),
            .INT_GNT  (int_gnt[g]),
            .INT_HOLD (int_hold[g]),
            .REF_REQ  (REF_REQ),
            .REF_DONE (REF_DONE),
            .REF_GNT  (ref_gnt[g]),
            .BRLS_N   (BRLS_N),
            .BGR_N    (bgr_n[g]),
            .BUS_HIZ  (bus_hiz[g]),
            .OWNER    (owner[g])
        );
    end

    // {OWNER, INT_GNT, REF_GNT, BGR_N, BUS_HIZ, INT_HOLD} expected per arbiter state
    function automatic logic [6:0] exp_bits(input bst_e s, input logic req);
        case (s)
            B_IDLE:  return {2'b00, 1'b0, 1'b0, 1'b1, 1'b0, req};
            B_INT:   return {2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
            B_REF:   return {2'b10, 1'b0, 1'b1, 1'b1, 1'b0, req};
            B_EXT:   return {2'b11, 1'b0, 1'b0, 1'b0, 1'b1, req};
            default: return {2'b00, 1'b0, 1'b0, 1'b1, 1'b1, req};
        endcase
    endfunction

    function automatic logic [6:0] obs_bits(input int d);
        return {owner[d], int_gnt[d], ref_gnt[d], bgr_n[d], bus_hiz[d], int_hold[d]};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string tag, input int d, input bst_e s);
        sb_t e;
        e.tag = tag;
        e.d   = d;
        e.exp = exp_bits(s, INT_REQ);
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        sb_t        e;
        logic [6:0] obs;
        e   = sb_q.pop_front();
        obs = obs_bits(e.d);
        vectors++;
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (owner,igt,rgt,bgr_n,hiz,hold)",
                   e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input string tag, input int d, input bst_e s);
        push(tag, d, s);
        tick();
        check_pop();
    endtask

    task automatic now(input string tag, input int d, input bst_e s);
        push(tag, d, s);
        #1;
        check_pop();
    endtask

    task automatic do_reset();
        RST_N    = 1'b0;
        CE_R     = 1'b1;
        INT_REQ  = 1'b0;
        INT_LOCK = 1'b0;
        BSC_BUSY = 1'b0;
        REF_REQ  = 1'b0;
        REF_DONE = 1'b0;
        BRLS_N   = 1'b1;
        repeat (2) tick();
        RST_N = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        CE_F = 1'b0;
        #1;
        // reset state, lock hold, drop to TOUT/EXT, async reset mid-EXT (TURN_CYC=1)
        do_reset();
        now("rst_d1", D1, B_IDLE);
        now("rst_d3", D3, B_IDLE);
        now("rst_d2", D2, B_IDLE);
        now("rst_d0", D0, B_IDLE);
        INT_REQ = 1'b1;
        now("hold_comb", D1, B_IDLE);
        step("int_gnt", D1, B_INT);
        INT_LOCK = 1'b1;
        BRLS_N   = 1'b0;
        repeat (50) tick();
        step("lock_hold", D1, B_INT);
        INT_LOCK = 1'b0;
        step("unlock", D1, B_IDLE);
        step("tout", D1, B_TOUT);
        step("ext", D1, B_EXT);
        RST_N = 1'b0;
        now("async_rst", D1, B_IDLE);

        // TURN_CYC=3: turn-out, EXT not preempted, turn-in, INT_FIRST fairness
        do_reset();
        BRLS_N = 1'b0;
        step("b_sync1", D3, B_IDLE);
        step("b_sync2", D3, B_IDLE);
        step("b_tout1", D3, B_TOUT);
        step("b_tout2", D3, B_TOUT);
        step("b_tout3", D3, B_TOUT);
        step("b_ext", D3, B_EXT);
        INT_REQ = 1'b1;
        BRLS_N  = 1'b1;
        step("b_ext_hold1", D3, B_EXT);
        step("b_ext_hold2", D3, B_EXT);
        step("b_tin1", D3, B_TIN);
        step("b_tin2", D3, B_TIN);
        BRLS_N = 1'b0;
        step("b_tin3", D3, B_TIN);
        step("b_idle", D3, B_IDLE);
        step("b_int_first", D3, B_INT);
        step("b_leave", D3, B_IDLE);
        step("b_ext_after", D3, B_TOUT);

        // refresh and external together at an INT boundary (TURN_CYC=1)
        do_reset();
        INT_REQ = 1'b1;
        step("c_int", D1, B_INT);
        BSC_BUSY = 1'b1;
        REF_REQ  = 1'b1;
        BRLS_N   = 1'b0;
        step("c_busy", D1, B_INT);
        BSC_BUSY = 1'b0;
        step("c_bound", D1, B_IDLE);
        step("c_ref", D1, B_REF);
        step("c_ref_hold", D1, B_REF);
        REF_DONE = 1'b1;
        REF_REQ  = 1'b0;
        step("c_done", D1, B_IDLE);
        REF_DONE = 1'b0;
        step("c_tout", D1, B_TOUT);
        step("c_ext", D1, B_EXT);

        // CE_R gating, BRLS_N pulse aborted during TOUT, stray REF_DONE (TURN_CYC=2)
        do_reset();
        CE_R    = 1'b0;
        INT_REQ = 1'b1;
        repeat (3) tick();
        now("d_ce_gate", D2, B_IDLE);
        INT_REQ = 1'b0;
        CE_R    = 1'b1;
        BRLS_N  = 1'b0;
        step("d_sync1", D2, B_IDLE);
        step("d_sync2", D2, B_IDLE);
        BRLS_N = 1'b1;
        step("d_tout1", D2, B_TOUT);
        step("d_tout2", D2, B_TOUT);
        step("d_abort", D2, B_IDLE);
        step("d_no_grant", D2, B_IDLE);
        INT_REQ = 1'b1;
        step("d_int", D2, B_INT);
        REF_DONE = 1'b1;
        step("d_stray_done", D2, B_INT);
        REF_DONE = 1'b0;

        // TURN_CYC=0: no turnaround states at all
        do_reset();
        BRLS_N = 1'b0;
        step("e_sync1", D0, B_IDLE);
        step("e_sync2", D0, B_IDLE);
        step("e_ext", D0, B_EXT);
        BRLS_N = 1'b1;
        step("e_hold1", D0, B_EXT);
        step("e_hold2", D0, B_EXT);
        step("e_idle", D0, B_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
